// File: rtl/bcd_alu_sequencer_pkg.sv
// bcd_alu_sequencer_pkg: shared state encoding, BCD constants and digit validity check.
package bcd_alu_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} state_e;
    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;
    function automatic logic bad_digit(input logic [NIBBLE_W-1:0] d);
        return d > BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_alu_sequencer_if.sv
// bcd_alu_sequencer_if: request/result handshake bundle between parser, engine and transmitter.
interface bcd_alu_sequencer_if import bcd_alu_sequencer_pkg::*; #(parameter int NDIG = 4);
    logic in_valid, in_ready, op_sub;
    logic [NIBBLE_W*NDIG-1:0] a_bcd, b_bcd;
    logic out_valid, out_ready, negative, error;
    logic [NIBBLE_W*NDIG+NIBBLE_W-1:0] result;
    modport slave (input in_valid, op_sub, a_bcd, b_bcd, out_ready,
                   output in_ready, out_valid, result, negative, error);
    modport master (output in_valid, op_sub, a_bcd, b_bcd, out_ready,
                    input in_ready, out_valid, result, negative, error);
endinterface

// File: rtl/bcd_alu_sequencer_digit_unit.sv
// bcd_digit_unit: one-digit BCD adder with optional 9's complement of the b digit.
module bcd_digit_unit import bcd_alu_sequencer_pkg::*; (
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    input  logic                comp_b_i,
    output logic [NIBBLE_W-1:0] f_o,
    output logic                cout_o
);
    logic [NIBBLE_W-1:0] b_eff;
    logic [NIBBLE_W:0]   sum;
    always_comb begin
        b_eff  = comp_b_i ? BCD_MAX - b_i : b_i;
        sum    = {1'b0, a_i} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, cin_i};
        cout_o = sum > {1'b0, BCD_MAX};
        f_o    = cout_o ? sum[NIBBLE_W-1:0] + NIBBLE_W'(6) : sum[NIBBLE_W-1:0];
    end
endmodule

// File: rtl/bcd_alu_sequencer.sv
// bcd_alu_sequencer: digit-serial BCD add/subtract; negative differences are
// re-complemented in a second pass through the same digit adder.
module bcd_alu_sequencer import bcd_alu_sequencer_pkg::*; #(
    parameter int NDIG = 4
) (
    input logic                clock,
    input logic                reset,
    bcd_alu_sequencer_if.slave bus
);
    localparam int OW    = NIBBLE_W * NDIG;
    localparam int IDX_W = NDIG > 1 ? $clog2(NDIG) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d, op_q, op_d, neg_q, neg_d, err_q, err_d;
    logic [OW-1:0]      a_q, a_d, b_q, b_d;
    logic [OW+NIBBLE_W-1:0] res_q, res_d;
    logic [NIBBLE_W-1:0] dig_a, dig_b, dig_f;
    logic               dig_comp, dig_cout, bad, last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            bad = bad | bad_digit(bus.a_bcd[i*NIBBLE_W +: NIBBLE_W]) | bad_digit(bus.b_bcd[i*NIBBLE_W +: NIBBLE_W]);
    end

    // COMP pass: 0 + (9 - R[idx]) + carry turns the 10's complement back into a magnitude
    assign last     = idx_q == IDX_W'(NDIG - 1);
    assign dig_a    = state_q == COMP ? '0 : a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign dig_b    = state_q == COMP ? res_q[idx_q*NIBBLE_W +: NIBBLE_W] : b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign dig_comp = state_q == COMP ? 1'b1 : op_q;

    bcd_digit_unit u_digit (
        .a_i      (dig_a),
        .b_i      (dig_b),
        .cin_i    (carry_q),
        .comp_b_i (dig_comp),
        .f_o      (dig_f),
        .cout_o   (dig_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        neg_d   = neg_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.a_bcd;
                b_d     = bus.b_bcd;
                op_d    = bus.op_sub;
                res_d   = '0;
                neg_d   = 1'b0;
                err_d   = bad;
                idx_d   = '0;
                carry_d = bus.op_sub;
                state_d = bad ? DONE : RUN;
            end
            RUN: begin
                res_d[idx_q*NIBBLE_W +: NIBBLE_W] = dig_f;
                carry_d = dig_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last) begin
                    idx_d = '0;
                    res_d[OW +: NIBBLE_W] = op_q ? '0 : {{(NIBBLE_W-1){1'b0}}, dig_cout};
                    state_d = (op_q && !dig_cout) ? COMP : DONE;
                    if (op_q && !dig_cout) carry_d = 1'b1;
                end
            end
            COMP: begin
                res_d[idx_q*NIBBLE_W +: NIBBLE_W] = dig_f;
                carry_d = dig_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last) begin
                    idx_d   = '0;
                    neg_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = res_q;
    assign bus.negative  = neg_q;
    assign bus.error     = err_q;
endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// tb_bcd_alu_sequencer: directed and random requests checked against an integer-arithmetic model.
module tb_bcd_alu_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;

    bcd_alu_sequencer_if #(.NDIG(4)) bus ();
    bcd_alu_sequencer #(.NDIG(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [19:0] int2bcd(input int v);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b, input int hold);
        int lat, ea, eb, diff, exp_lat;
        logic exp_err, exp_neg;
        logic [19:0] exp_res, held;
        exp_err = has_bad(a) || has_bad(b);
        ea = bcd2int(a);
        eb = bcd2int(b);
        diff = op ? ea - eb : ea + eb;
        exp_neg = !exp_err && diff < 0;
        exp_res = exp_err ? 20'h0 : int2bcd(diff < 0 ? -diff : diff);
        exp_lat = exp_err ? 1 : (exp_neg ? 9 : 5);
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op_sub   = op;
        bus.a_bcd    = a;
        bus.b_bcd    = b;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clock);
            #1 lat++;
        end
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", 32'(bus.result), 32'(exp_res));
        check("negative", 32'(bus.negative), 32'(exp_neg));
        check("error", 32'(bus.error), 32'(exp_err));
        held = bus.result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.op_sub   = 1'($urandom_range(0, 1));
            bus.a_bcd    = 16'h0101;
            bus.b_bcd    = 16'h0909;
            @(posedge clock);
            #1;
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_ready", 32'(bus.in_ready), 32'd0);
            check("hold_result", 32'(bus.result), 32'(held));
            check("hold_neg", 32'(bus.negative), 32'(exp_neg));
        end
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [15:0] rand_operand();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) v[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.a_bcd     = '0;
        bus.b_bcd     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", {30'd0, bus.negative, bus.error}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(1'b0, 16'h1234, 16'h5678, 0);
        run_op(1'b0, 16'h9999, 16'h0001, 0);
        run_op(1'b1, 16'h5000, 16'h1234, 0);
        run_op(1'b1, 16'h1234, 16'h1234, 0);
        run_op(1'b1, 16'h1234, 16'h5000, 0);
        run_op(1'b0, 16'h12A4, 16'h0000, 0);
        run_op(1'b0, 16'h9999, 16'h9999, 3);
        run_op(1'b1, 16'h0000, 16'h9999, 3);

        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.op_sub   = 1'b0;
        bus.a_bcd    = 16'h4321;
        bus.b_bcd    = 16'h1111;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_flags", {30'd0, bus.negative, bus.error}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1 if (bus.out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        for (int n = 0; n < 40; n++)
            run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(), $urandom_range(0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
